// File: rtl/fetch_queue_if.sv
// fetch_queue_if: groups the fetch front-end signals into one bundle.
//   request  : req_valid/req_ready/req_addr        (fetch unit -> memory)
//   response : rsp_valid/rsp_data/rsp_err          (memory -> fetch unit, in order)
//   output   : out_valid/out_ready/out_instr/out_pc/out_fault (fetch unit -> decode)
//   redirect : redirect_valid/redirect_pc          (core -> fetch unit)
//   status   : empty/full
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        empty;
  logic        full;

  modport master (
    output req_valid, req_addr,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_err,
    output out_valid, out_instr, out_pc, out_fault,
    input  out_ready,
    input  redirect_valid, redirect_pc,
    output empty, full
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready,
    output rsp_valid, rsp_data, rsp_err,
    input  out_valid, out_instr, out_pc, out_fault,
    output out_ready,
    output redirect_valid, redirect_pc,
    input  empty, full
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch front end. Issues in-order fetch
// requests (at most MAX_OUTSTANDING in flight), buffers the returned
// instructions with their PCs in a DEPTH-entry queue and hands them to decode
// over a valid/ready handshake. A redirect flushes the queue, restarts fetch at
// the new PC and drops every response still in flight.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   fq    : fetch_queue_if.master (request, response, output, redirect, status)
// Option macro FETCH_QUEUE_BYPASS_EN: when defined, a response arriving at an
// empty queue is presented on out_* in the same cycle (and not written if it is
// consumed immediately). Undefined: out_* is driven from the queue only.
module fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.master fq
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  logic [31:0]   fpc_q, fpc_d, rpc_q, rpc_d;
  logic [CW-1:0] outs_q, outs_d, drop_q, drop_d, occ_q, occ_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic          req_fire, rsp_keep, push, pop, show_valid;
  logic [SW-1:0] credit_sum;
  entry_t        rsp_entry, show;

  always_comb begin
    // Credit check: every issued request owns a queue slot, so a response can
    // never find the queue full.
    credit_sum   = {1'b0, occ_q} + {1'b0, outs_q};
    fq.req_valid = !reset && !fq.redirect_valid &&
                   (outs_q < CW'(MAX_OUTSTANDING)) && (credit_sum < SW'(DEPTH));
    fq.req_addr  = fpc_q;
    req_fire     = fq.req_valid && fq.req_ready;

    // A response arriving during a redirect is stale, as is any counted in drop_q.
    rsp_keep  = fq.rsp_valid && (drop_q == '0) && !fq.redirect_valid;
    rsp_entry = '{instr: fq.rsp_data, pc: rpc_q, fault: fq.rsp_err};

    show       = mem_q[rd_q];
    show_valid = (occ_q != '0);
    pop        = show_valid && fq.out_ready && !fq.redirect_valid;
    push       = rsp_keep;
`ifdef FETCH_QUEUE_BYPASS_EN
    if ((occ_q == '0) && rsp_keep) begin
      show       = rsp_entry;
      show_valid = 1'b1;
      // Consumed straight from the response: never enters the queue.
      push       = !fq.out_ready;
    end
`endif

    fq.out_valid = show_valid;
    fq.out_instr = show_valid ? show.instr : '0;
    fq.out_pc    = show_valid ? show.pc    : '0;
    fq.out_fault = show_valid ? show.fault : 1'b0;
    fq.empty     = (occ_q == '0);
    fq.full      = (occ_q == CW'(DEPTH));

    outs_d = outs_q + CW'(req_fire) - CW'(fq.rsp_valid);
    mem_d  = mem_q;
    if (fq.redirect_valid) begin
      fpc_d  = fq.redirect_pc & ~32'd3;
      rpc_d  = fq.redirect_pc & ~32'd3;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d = outs_d;
      occ_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
    end else begin
      fpc_d  = req_fire ? fpc_q + 32'd4 : fpc_q;
      rpc_d  = rsp_keep ? rpc_q + 32'd4 : rpc_q;
      drop_d = (fq.rsp_valid && (drop_q != '0)) ? drop_q - 1'b1 : drop_q;
      occ_d  = occ_q + CW'(push) - CW'(pop);
      rd_d   = pop  ? rd_q + 1'b1 : rd_q;
      wr_d   = push ? wr_q + 1'b1 : wr_q;
      if (push) mem_d[wr_q] = rsp_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fpc_q  <= RESET_PC;
      rpc_q  <= RESET_PC;
      outs_q <= '0;
      drop_q <= '0;
      occ_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
      outs_q <= outs_d;
      drop_q <= drop_d;
      occ_q  <= occ_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      mem_q  <= mem_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed testbench for fetch_queue (default build,
// DEPTH=4, MAX_OUTSTANDING=2). A 1-cycle-latency memory returns addr^K and
// flags an access fault for ERR_ADDR; scenarios can switch to manual responses.
module tb_fetch_queue;
  localparam logic [31:0] K        = 32'hA5A5_0000;
  localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_queue_if fq_if();

  fetch_queue #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h8000_0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fq(fq_if)
  );

  int passed = 0;
  int total  = 0;

  logic        auto_en  = 1'b1;
  logic        man_v    = 1'b0;
  logic        man_err  = 1'b0;
  logic [31:0] man_data = '0;
  logic        fire_s   = 1'b0;
  logic [31:0] addr_s   = '0;
  logic        mem_v    = 1'b0;
  logic [31:0] mem_a    = '0;

  // Memory model: a request accepted at the end of cycle N answers in cycle N+1.
  always @(negedge clock) begin
    fire_s = fq_if.req_valid & fq_if.req_ready;
    addr_s = fq_if.req_addr;
  end
  always @(posedge clock) begin
    #1;
    mem_v = fire_s;
    mem_a = addr_s;
  end

  assign fq_if.rsp_valid = auto_en ? mem_v : man_v;
  assign fq_if.rsp_data  = auto_en ? (mem_a ^ K) : man_data;
  assign fq_if.rsp_err   = auto_en ? (mem_a == ERR_ADDR) : man_err;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_defaults();
    auto_en              = 1'b1;
    man_v                = 1'b0;
    man_err              = 1'b0;
    man_data             = '0;
    fq_if.req_ready      = 1'b1;
    fq_if.out_ready      = 1'b0;
    fq_if.redirect_valid = 1'b0;
    fq_if.redirect_pc    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_defaults();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_defaults();
    tick();
    @(negedge clock);
    total++; if (fq_if.req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", fq_if.req_valid); else passed++;
    total++; if (fq_if.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", fq_if.out_valid); else passed++;
    total++; if (fq_if.out_instr !== 32'h0) $display("FAIL rst_out_instr: got %h want 0", fq_if.out_instr); else passed++;
    total++; if (fq_if.out_pc !== 32'h0) $display("FAIL rst_out_pc: got %h want 0", fq_if.out_pc); else passed++;
    total++; if (fq_if.out_fault !== 1'b0) $display("FAIL rst_out_fault: got %b want 0", fq_if.out_fault); else passed++;
    total++; if (fq_if.empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", fq_if.empty); else passed++;
    total++; if (fq_if.full !== 1'b0) $display("FAIL rst_full: got %b want 0", fq_if.full); else passed++;
    tick();
    reset = 1'b0;
    @(negedge clock);
    total++; if (fq_if.req_valid !== 1'b1) $display("FAIL rst_first_req: got %b want 1", fq_if.req_valid); else passed++;
    total++; if (fq_if.req_addr !== 32'h8000_0000) $display("FAIL rst_first_addr: got %h want 80000000", fq_if.req_addr); else passed++;
  endtask

  // Streaming at one instruction per cycle; the entry for 8000_0008 faults.
  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    fq_if.out_ready = 1'b1;
    @(negedge clock);
    total++; if (fq_if.req_addr !== 32'h8000_0000) $display("FAIL stream_addr0: got %h want 80000000", fq_if.req_addr); else passed++;
    tick();
    @(negedge clock);
    total++; if (fq_if.req_addr !== 32'h8000_0004) $display("FAIL stream_addr1: got %h want 80000004", fq_if.req_addr); else passed++;
    total++; if (fq_if.out_valid !== 1'b0) $display("FAIL stream_latency: got %b want 0", fq_if.out_valid); else passed++;
    tick();
    for (int k = 0; k < 8; k++) begin
      e = 32'h8000_0000 + 32'(4 * k);
      @(negedge clock);
      total++; if (fq_if.out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", k, fq_if.out_valid); else passed++;
      total++; if (fq_if.out_pc !== e) $display("FAIL stream_pc[%0d]: got %h want %h", k, fq_if.out_pc, e); else passed++;
      total++; if (fq_if.out_instr !== (e ^ K)) $display("FAIL stream_instr[%0d]: got %h want %h", k, fq_if.out_instr, e ^ K); else passed++;
      total++; if (fq_if.out_fault !== (k == 2)) $display("FAIL stream_fault[%0d]: got %b want %b", k, fq_if.out_fault, (k == 2)); else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    repeat (7) tick();
    @(negedge clock);
    total++; if (fq_if.full !== 1'b1) $display("FAIL bp_full: got %b want 1", fq_if.full); else passed++;
    total++; if (fq_if.empty !== 1'b0) $display("FAIL bp_empty: got %b want 0", fq_if.empty); else passed++;
    total++; if (fq_if.req_valid !== 1'b0) $display("FAIL bp_req_valid: got %b want 0", fq_if.req_valid); else passed++;
    total++; if (fq_if.out_pc !== 32'h8000_0000) $display("FAIL bp_head: got %h want 80000000", fq_if.out_pc); else passed++;
    tick();
    fq_if.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e = 32'h8000_0000 + 32'(4 * k);
      @(negedge clock);
      total++; if (fq_if.out_valid !== 1'b1) $display("FAIL bp_drain_valid[%0d]: got %b want 1", k, fq_if.out_valid); else passed++;
      total++; if (fq_if.out_pc !== e) $display("FAIL bp_drain_pc[%0d]: got %h want %h", k, fq_if.out_pc, e); else passed++;
      tick();
    end
  endtask

  // Two requests in flight, redirect to 8000_0103: both stale responses dropped.
  task automatic test_redirect();
    do_reset();
    auto_en         = 1'b0;
    fq_if.out_ready = 1'b1;
    tick();
    @(negedge clock);
    total++; if (fq_if.req_addr !== 32'h8000_0004) $display("FAIL rd_addr1: got %h want 80000004", fq_if.req_addr); else passed++;
    tick();
    fq_if.redirect_valid = 1'b1;
    fq_if.redirect_pc    = 32'h8000_0103;
    @(negedge clock);
    total++; if (fq_if.req_valid !== 1'b0) $display("FAIL rd_req_gated: got %b want 0", fq_if.req_valid); else passed++;
    tick();
    fq_if.redirect_valid = 1'b0;
    man_v    = 1'b1;
    man_data = 32'hDEAD_BEEF;
    @(negedge clock);
    total++; if (fq_if.req_addr !== 32'h8000_0100) $display("FAIL rd_new_addr: got %h want 80000100", fq_if.req_addr); else passed++;
    total++; if (fq_if.out_valid !== 1'b0) $display("FAIL rd_out_valid_n1: got %b want 0", fq_if.out_valid); else passed++;
    tick();
    @(negedge clock);
    total++; if (fq_if.empty !== 1'b1) $display("FAIL rd_stale1_dropped: got %b want 1", fq_if.empty); else passed++;
    total++; if (fq_if.req_valid !== 1'b1) $display("FAIL rd_req_resume: got %b want 1", fq_if.req_valid); else passed++;
    total++; if (fq_if.req_addr !== 32'h8000_0100) $display("FAIL rd_req_resume_addr: got %h want 80000100", fq_if.req_addr); else passed++;
    tick();
    man_v   = 1'b0;
    auto_en = 1'b1;
    @(negedge clock);
    total++; if (fq_if.out_valid !== 1'b0) $display("FAIL rd_stale2_dropped: got %b want 0", fq_if.out_valid); else passed++;
    tick();
    @(negedge clock);
    total++; if (fq_if.out_pc !== 32'h8000_0100) $display("FAIL rd_first_pc: got %h want 80000100", fq_if.out_pc); else passed++;
    total++; if (fq_if.out_instr !== (32'h8000_0100 ^ K)) $display("FAIL rd_first_instr: got %h want %h", fq_if.out_instr, 32'h8000_0100 ^ K); else passed++;
    tick();
    @(negedge clock);
    total++; if (fq_if.out_pc !== 32'h8000_0104) $display("FAIL rd_second_pc: got %h want 80000104", fq_if.out_pc); else passed++;
  endtask

  // Redirect coinciding with a response and a pop.
  task automatic test_redirect_pop();
    do_reset();
    fq_if.out_ready = 1'b1;
    repeat (4) tick();
    fq_if.redirect_valid = 1'b1;
    fq_if.redirect_pc    = 32'h9000_0000;
    @(negedge clock);
    total++; if (fq_if.out_valid !== 1'b1) $display("FAIL rp_busy_valid: got %b want 1", fq_if.out_valid); else passed++;
    total++; if (fq_if.req_valid !== 1'b0) $display("FAIL rp_req_gated: got %b want 0", fq_if.req_valid); else passed++;
    tick();
    fq_if.redirect_valid = 1'b0;
    @(negedge clock);
    total++; if (fq_if.out_valid !== 1'b0) $display("FAIL rp_out_valid: got %b want 0", fq_if.out_valid); else passed++;
    total++; if (fq_if.empty !== 1'b1) $display("FAIL rp_empty: got %b want 1", fq_if.empty); else passed++;
    total++; if (fq_if.req_addr !== 32'h9000_0000) $display("FAIL rp_new_addr: got %h want 90000000", fq_if.req_addr); else passed++;
    total++; if (fq_if.req_valid !== 1'b1) $display("FAIL rp_req_valid: got %b want 1", fq_if.req_valid); else passed++;
    tick();
    tick();
    @(negedge clock);
    total++; if (fq_if.out_pc !== 32'h9000_0000) $display("FAIL rp_first_pc: got %h want 90000000", fq_if.out_pc); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    fq_if.out_ready      = 1'b1;
    fq_if.redirect_valid = 1'b1;
    fq_if.redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clock);
    total++; if (fq_if.req_valid !== 1'b0) $display("FAIL wrap_req_gated: got %b want 0", fq_if.req_valid); else passed++;
    tick();
    fq_if.redirect_valid = 1'b0;
    @(negedge clock);
    total++; if (fq_if.req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", fq_if.req_addr); else passed++;
    tick();
    @(negedge clock);
    total++; if (fq_if.req_addr !== 32'h0000_0000) $display("FAIL wrap_addr1: got %h want 00000000", fq_if.req_addr); else passed++;
    tick();
    @(negedge clock);
    total++; if (fq_if.out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0: got %h want fffffffc", fq_if.out_pc); else passed++;
    tick();
    @(negedge clock);
    total++; if (fq_if.out_pc !== 32'h0000_0000) $display("FAIL wrap_pc1: got %h want 00000000", fq_if.out_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
